openstrive_soc_mem_ctrl: RTL and testbench
==========================================

# openstrive_soc_mem_ctrl

Bridge between the Ibex-style core data port (req/gnt/rvalid) and the single-port synchronous SoC SRAM macro (ena/wen/addr/wdata/rdata, 1-cycle read latency). It initiates all SRAM accesses. After reset it zero-fills the whole SRAM, then serves one core request per cycle. Accesses outside the SRAM range are rejected with a bus error, and the SRAM is not touched.

## Interface
- WORDS, 16: SRAM depth in 32-bit words; must be ≥2 and ≤ 2^22.
- INIT_ZERO, 1: 1 = zero-fill the SRAM after reset; 0 = go straight to service.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- data_req_i  in  1  core request valid.
- data_gnt_o  out  1  request accepted this cycle (combinational).
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables for writes.
- data_addr_i  in  32  byte address; word index = data_addr_i[31:2], bits [1:0] ignored.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid, exactly one per grant.
- data_rdata_o  out  32  read data; 0 on writes and on errors.
- data_err_o  out  1  response is an error; qualified by data_rvalid_o.
- init_done_o  out  1  high once the zero-fill is complete, or immediately when INIT_ZERO=0.
- mem_ena_o  out  1  SRAM enable.
- mem_wen_o  out  4  SRAM byte write enables.
- mem_addr_o  out  22  SRAM word address.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM registered read data.

## Operation
- FSM states are INIT and SERVE.
- Reset enters INIT when INIT_ZERO=1, otherwise SERVE. The init counter resets to 0.
- INIT, every cycle:
  - Drive mem_ena_o=1, mem_wen_o=4'hF, mem_wdata_o=0, mem_addr_o=counter.
  - Increment the counter.
  - When counter==WORDS-1, write that word and move to SERVE in the next cycle.
  - data_gnt_o=0 throughout.
- SERVE:
  - data_gnt_o = data_req_i.
  - On a grant where word index < WORDS:
    - mem_ena_o=1, mem_addr_o = index[21:0].
    - Write: mem_wen_o = data_be_i and mem_wdata_o = data_wdata_i.
    - Read: mem_wen_o = 0. A write with data_be_i=0 behaves as a no-op write.
  - On a grant where word index ≥ WORDS (compare on the full 30-bit index, no truncation):
    - mem_ena_o=0.
    - Register an error response.
- Outside a valid grant in SERVE: mem_ena_o=0, mem_wen_o=0, mem_addr_o=0, mem_wdata_o=0.
- Response registers, set at the grant edge: rsp_valid, rsp_read (read and not error), rsp_err.
  - data_rvalid_o = rsp_valid.
  - data_err_o = rsp_valid & rsp_err.
  - data_rdata_o = (rsp_valid & rsp_read) ? mem_rdata_i : 0.
- init_done_o is 1 exactly when the state is SERVE.

## Timing
- Reset values: data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0, init_done_o=0 (1 when INIT_ZERO=0), mem_wen_o=4'hF.
  - When INIT_ZERO=1, mem_ena_o=1 during reset and INIT.
  - When INIT_ZERO=0, all mem_* outputs are 0.
- The zero-fill takes exactly WORDS cycles after reset deassertion. init_done_o rises in cycle WORDS (counting from 0).
- Grant latency is 0 cycles (same cycle as req in SERVE). Response latency is exactly 1 cycle after the grant, for hits and errors alike.
- Back-to-back requests: one grant per cycle, no bubbles. The response for request N appears in the same cycle as the grant for N+1.
- Read-after-write to the same address in consecutive cycles returns the newly written data, because the SRAM write commits before the next read.
- A request held during INIT is not granted. It is granted in the first SERVE cycle.
- Reset mid-INIT restarts the zero-fill from word 0.
- Reset with a response pending drops that response; rvalid is 0 during reset.
- WORDS-1 wrap: no counter overflow. The counter width is $clog2(WORDS)+1.

## Structure
- Shared package openstrive_soc_pkg holds:
  - the FSM state typedef (INIT, SERVE);
  - MEM_ADDR_W=22;
  - BUS_ADDR_W=32;
  - BE_W=4.
- Natural sub-module: openstrive_soc_mem_init, the zero-fill counter with done flag. It drives the mem_* outputs during INIT through a mux in the top.

## Test plan
- Reset, WORDS=16, INIT_ZERO=1 -> 16 cycles of mem_ena=1, wen=F, wdata=0, addr 0..15, then init_done_o=1; a req held throughout is granted in cycle 16.
- Write 0xDEADBEEF to addr 0x8 with be=F, then read 0x8 next cycle -> rvalid one cycle after each grant; read returns 0xDEADBEEF, err=0.
- Write 0x000000AA at be=4'b0001 to a word holding 0x11223344, then read it -> 0x112233AA.
- Read addr 0x40 (index 16 ≥ WORDS) -> gnt=1, mem_ena=0, next cycle rvalid=1, err=1, rdata=0; also addr 0x8000_0008 must error (no index truncation).
- Four back-to-back reads of words 0..3 after pre-writing 1..4 -> continuous gnt, rvalid in four consecutive cycles with data 1, 2, 3, 4.
- Assert rst at the init counter value 7, and separately during a pending read response -> the zero-fill restarts at addr 0, and no rvalid appears for the dropped request.

Source files
------------

// File: rtl/openstrive_soc_pkg.sv
// openstrive_soc_pkg: shared widths and FSM state encoding for the SoC memory controller.
package openstrive_soc_pkg;
  localparam int MEM_ADDR_W = 22;
  localparam int BUS_ADDR_W = 32;
  localparam int BE_W = 4;
  typedef logic [0:0] state_t;
  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_SERVE = 1'b1;
endpackage

// File: rtl/openstrive_soc_mem_init.sv
// openstrive_soc_mem_init: zero-fill word counter, flags the last word of the fill.
module openstrive_soc_mem_init #(
  parameter int WORDS = 16,
  localparam int CW = $clog2(WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt_o,
  output logic          done_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
  assign done_o = en && cnt_q == CW'(WORDS - 1);
endmodule

// File: rtl/openstrive_soc_mem_ctrl.sv
// openstrive_soc_mem_ctrl: core data port to single-port SRAM bridge with
// post-reset zero-fill and out-of-range bus errors.
module openstrive_soc_mem_ctrl
  import openstrive_soc_pkg::*;
#(
  parameter int WORDS = 16,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic                  data_we_i,
  input  logic [BE_W-1:0]       data_be_i,
  input  logic [BUS_ADDR_W-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  init_done_o,
  output logic                  mem_ena_o,
  output logic [BE_W-1:0]       mem_wen_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);
  localparam int CW = $clog2(WORDS) + 1;
  state_t state_q, state_d;
  logic rsp_valid_q, rsp_valid_d, rsp_read_q, rsp_read_d, rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt;
  logic [29:0] idx;
  logic init, init_last, hit, acc, addr_unused;
  openstrive_soc_mem_init #(.WORDS(WORDS)) u_init (
    .clk(clk), .rst(rst), .en(init), .cnt_o(cnt), .done_o(init_last)
  );
  assign idx = data_addr_i[31:2];
  assign addr_unused = ^data_addr_i[1:0];
  assign init = state_q == ST_INIT;
  // Full 30-bit compare so high address bits can never alias into the SRAM.
  assign hit = idx < 30'(WORDS);
  assign data_gnt_o = !rst && !init && data_req_i;
  assign acc = data_gnt_o && hit;
  always_comb begin
    state_d = (init && init_last) ? ST_SERVE : state_q;
    rsp_valid_d = data_gnt_o;
    rsp_read_d = acc && !data_we_i;
    rsp_err_d = data_gnt_o && !hit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_ZERO ? ST_INIT : ST_SERVE;
      rsp_valid_q <= 1'b0;
      rsp_read_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_read_q <= rsp_read_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign mem_ena_o = init || acc;
  assign mem_wen_o = init ? '1 : (acc && data_we_i) ? data_be_i : '0;
  assign mem_addr_o = init ? MEM_ADDR_W'(cnt) : acc ? idx[MEM_ADDR_W-1:0] : '0;
  assign mem_wdata_o = (!init && acc && data_we_i) ? data_wdata_i : '0;
  assign data_rvalid_o = rsp_valid_q;
  assign data_err_o = rsp_valid_q && rsp_err_q;
  assign data_rdata_o = (rsp_valid_q && rsp_read_q) ? mem_rdata_i : '0;
  assign init_done_o = !init;
endmodule

// File: tb/tb_openstrive_soc_mem_ctrl.sv
// tb_openstrive_soc_mem_ctrl: directed table, hand sequences and random traffic
// checked against a word-array scoreboard of the SRAM contents.
module tb_openstrive_soc_mem_ctrl;
  localparam int WORDS = 16;
  logic clk, rst;
  logic data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o, init_done_o;
  logic [3:0] data_be_i, mem_wen_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o, mem_wdata_o, mem_rdata_i;
  logic mem_ena_o;
  logic [21:0] mem_addr_o;
  logic [31:0] sram [WORDS];
  logic [31:0] ref_mem [WORDS];
  int cyc, n_chk, n_fail;
  logic exp_v, exp_e;
  logic [31:0] exp_d;
  typedef struct {
    logic req, we;
    logic [3:0] be;
    logic [31:0] addr, wd;
    logic gnt, ena, v, e;
    logic [31:0] d;
  } vec_t;
  vec_t tbl [18];

  openstrive_soc_mem_ctrl #(.WORDS(WORDS), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o), .init_done_o(init_done_o), .mem_ena_o(mem_ena_o),
    .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: byte-masked writes, registered read data.
  initial begin
    for (int i = 0; i < WORDS; i++) sram[i] = $urandom;
    mem_rdata_i = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_ena_o && mem_addr_o < 22'(WORDS)) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      if (mem_wen_o == 4'h0) mem_rdata_i <= sram[mem_addr_o];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(data_gnt_o), 0);
    chk("rst_rvalid", 32'(data_rvalid_o), 0);
    chk("rst_err", 32'(data_err_o), 0);
    chk("rst_rdata", data_rdata_o, 0);
    chk("rst_init_done", 32'(init_done_o), 0);
    chk("rst_mem_ena", 32'(mem_ena_o), 1);
    chk("rst_mem_wen", 32'(mem_wen_o), 32'hF);
    chk("rst_mem_addr", 32'(mem_addr_o), 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    cyc = 0;
    exp_v = 1'b0;
  endtask

  task automatic step(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic serve, hit;
    int idx;
    @(negedge clk);
    data_req_i = req; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wd;
    #1;
    serve = cyc >= WORDS;
    hit = addr[31:2] < WORDS;
    idx = int'(addr[31:2]);
    chk("init_done", 32'(init_done_o), 32'(serve));
    chk("gnt", 32'(data_gnt_o), 32'(req && serve));
    chk("rvalid", 32'(data_rvalid_o), 32'(exp_v));
    chk("err", 32'(data_err_o), 32'(exp_v && exp_e));
    chk("rdata", data_rdata_o, exp_v ? exp_d : 32'h0);
    if (!serve) begin
      chk("fill_ena", 32'(mem_ena_o), 1);
      chk("fill_wen", 32'(mem_wen_o), 32'hF);
      chk("fill_addr", 32'(mem_addr_o), 32'(cyc));
      chk("fill_wdata", mem_wdata_o, 0);
      ref_mem[cyc] = 32'h0;
      exp_v = 1'b0;
    end else begin
      chk("mem_ena", 32'(mem_ena_o), 32'(req && hit));
      chk("mem_addr", 32'(mem_addr_o), (req && hit) ? 32'(idx) : 0);
      chk("mem_wen", 32'(mem_wen_o), (req && hit && we) ? 32'(be) : 0);
      chk("mem_wdata", mem_wdata_o, (req && hit && we) ? wd : 0);
      exp_v = req;
      exp_e = !hit;
      exp_d = (hit && !we) ? ref_mem[idx] : 32'h0;
      if (req && hit && we)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
    end
    cyc++;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; exp_v = 0; exp_e = 0; exp_d = 0;
    rst = 1'b1;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 0; data_wdata_i = 0;
    tbl[0]  = '{1, 1, 4'hF, 32'h8, 32'hDEADBEEF, 1, 1, 1, 0, 32'h0};
    tbl[1]  = '{1, 0, 4'hF, 32'h8, 32'h0, 1, 1, 1, 0, 32'h0};
    tbl[2]  = '{1, 1, 4'hF, 32'hC, 32'h11223344, 1, 1, 1, 0, 32'hDEADBEEF};
    tbl[3]  = '{1, 1, 4'h1, 32'hC, 32'h000000AA, 1, 1, 1, 0, 32'h0};
    tbl[4]  = '{1, 0, 4'hF, 32'hC, 32'h0, 1, 1, 1, 0, 32'h0};
    tbl[5]  = '{1, 0, 4'hF, 32'h40, 32'h0, 1, 0, 1, 0, 32'h112233AA};
    tbl[6]  = '{1, 0, 4'hF, 32'h80000008, 32'h0, 1, 0, 1, 1, 32'h0};
    tbl[7]  = '{1, 1, 4'hF, 32'h0, 32'h1, 1, 1, 1, 1, 32'h0};
    tbl[8]  = '{1, 1, 4'hF, 32'h4, 32'h2, 1, 1, 1, 0, 32'h0};
    tbl[9]  = '{1, 1, 4'hF, 32'h8, 32'h3, 1, 1, 1, 0, 32'h0};
    tbl[10] = '{1, 1, 4'hF, 32'hC, 32'h4, 1, 1, 1, 0, 32'h0};
    tbl[11] = '{1, 0, 4'hF, 32'h0, 32'h0, 1, 1, 1, 0, 32'h0};
    tbl[12] = '{1, 0, 4'hF, 32'h4, 32'h0, 1, 1, 1, 0, 32'h1};
    tbl[13] = '{1, 0, 4'hF, 32'h8, 32'h0, 1, 1, 1, 0, 32'h2};
    tbl[14] = '{1, 0, 4'hF, 32'hC, 32'h0, 1, 1, 1, 0, 32'h3};
    tbl[15] = '{0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 0, 32'h4};
    tbl[16] = '{0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0};
    tbl[17] = '{0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0};
    do_reset();
    // Request held through the fill; granted only in cycle WORDS.
    for (int i = 0; i <= WORDS; i++) step(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd);
      chk($sformatf("tbl%0d_gnt", i), 32'(data_gnt_o), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_ena", i), 32'(mem_ena_o), 32'(tbl[i].ena));
      chk($sformatf("tbl%0d_rvalid", i), 32'(data_rvalid_o), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_err", i), 32'(data_err_o), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_rdata", i), data_rdata_o, tbl[i].d);
    end
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, WORDS + 3), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
      step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), a, $urandom);
    end
    // Reset mid-fill at counter 7 restarts from word 0.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("mid_init_addr", 32'(mem_addr_o), 6);
    do_reset();
    for (int i = 0; i < WORDS; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 4'hF, 32'h4, 32'hCAFE0001);
    // Reset with a read response pending drops it.
    step(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    do_reset();
    for (int i = 0; i < WORDS; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("after_refill_rdata", data_rdata_o, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
